// File: rtl/simple_processor_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : simple_processor_pkg                                         |
// | Description : Shared types and constants for the simple processor datapath.|
// | Revision    : 1.1 - issue unit state type and instruction field offsets    |
// +----------------------------------------------------------------------------+
`default_nettype none

package simple_processor_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int INSTR_WIDTH    = 32;

  // Logic instruction field offsets
  localparam int FUNC_LSB = 0;
  localparam int RD_LSB   = 2;
  localparam int RS1_LSB  = 7;
  localparam int RS2_LSB  = 12;
  localparam int RSVD_LSB = 17;

  typedef enum logic [1:0] {
    FUNC_AND = 2'd0,
    FUNC_OR  = 2'd1,
    FUNC_XOR = 2'd2,
    FUNC_NOT = 2'd3
  } func_t;

  typedef enum logic [1:0] {
    ISSUE_IDLE   = 2'd0,
    ISSUE_DECODE = 2'd1,
    ISSUE_EXEC   = 2'd2,
    ISSUE_WB     = 2'd3
  } issue_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_gate.sv
// +----------------------------------------------------------------------------+
// | Module      : alu_gate                                                     |
// | Description : Combinational bitwise logic ALU (AND, OR, XOR, NOT).         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_gate #(
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]       rs1_i,
  input  logic [DATA_WIDTH-1:0]       rs2_i,
  input  simple_processor_pkg::func_t func_i,
  output logic [DATA_WIDTH-1:0]       rd_o
);

  import simple_processor_pkg::*;

  always_comb begin
    rd_o = '0;
    case (func_i)
      FUNC_AND: rd_o = rs1_i & rs2_i;
      FUNC_OR:  rd_o = rs1_i | rs2_i;
      FUNC_XOR: rd_o = rs1_i ^ rs2_i;
      FUNC_NOT: rd_o = ~rs1_i;
      default:  rd_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/gate_issue_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : gate_issue_unit                                              |
// | Description : Four-state issue controller feeding alu_gate from a register |
// |               file: decode, operand read, execute, write back.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module gate_issue_unit #(
  parameter int DATA_WIDTH     = simple_processor_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = simple_processor_pkg::REG_ADDR_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  input  logic [31:0]                 instr_i,
  input  logic                        instr_valid_i,
  output logic                        instr_ready_o,
  output logic [REG_ADDR_WIDTH-1:0]   rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0]   rs2_addr_o,
  input  logic [DATA_WIDTH-1:0]       rs1_rdata_i,
  input  logic [DATA_WIDTH-1:0]       rs2_rdata_i,
  output logic [DATA_WIDTH-1:0]       alu_rs1_o,
  output logic [DATA_WIDTH-1:0]       alu_rs2_o,
  output simple_processor_pkg::func_t alu_func_o,
  input  logic [DATA_WIDTH-1:0]       alu_rd_i,
  output logic                        rd_we_o,
  output logic [REG_ADDR_WIDTH-1:0]   rd_addr_o,
  output logic [DATA_WIDTH-1:0]       rd_wdata_o,
  output logic                        done_o,
  output logic                        illegal_o,
  output logic [31:0]                 retire_cnt_o
);

  import simple_processor_pkg::*;

  issue_state_t              r_state;
  logic [31:0]               r_instr;
  logic [DATA_WIDTH-1:0]     r_op1;
  logic [DATA_WIDTH-1:0]     r_op2;
  func_t                     r_func;
  logic [DATA_WIDTH-1:0]     r_result;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [31:0]               r_retire_cnt;

  logic                      w_rsvd_nz;
  logic                      w_illegal;
  logic                      w_wb;

  assign w_rsvd_nz = |r_instr[31:RSVD_LSB];
  assign w_illegal = (r_state == ISSUE_DECODE) && w_rsvd_nz;
  assign w_wb      = (r_state == ISSUE_WB);

  // Every visible datapath output comes from a register so it holds between instructions
  assign rs1_addr_o    = r_instr[RS1_LSB +: REG_ADDR_WIDTH];
  assign rs2_addr_o    = r_instr[RS2_LSB +: REG_ADDR_WIDTH];
  assign alu_rs1_o     = r_op1;
  assign alu_rs2_o     = r_op2;
  assign alu_func_o    = r_func;
  assign rd_addr_o     = r_rd;
  assign rd_wdata_o    = r_result;
  assign retire_cnt_o  = r_retire_cnt;

  assign instr_ready_o = (r_state == ISSUE_IDLE) && !arst_i;
  assign rd_we_o       = w_wb && (r_rd != '0);
  assign done_o        = w_wb || w_illegal;
  assign illegal_o     = w_illegal;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state      <= ISSUE_IDLE;
      r_instr      <= '0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_func       <= FUNC_AND;
      r_result     <= '0;
      r_rd         <= '0;
      r_retire_cnt <= '0;
    end else begin
      case (r_state)
        ISSUE_IDLE: begin
          if (instr_valid_i) begin
            r_instr <= instr_i;
            r_state <= ISSUE_DECODE;
          end
        end
        ISSUE_DECODE: begin
          r_op1  <= rs1_rdata_i;
          r_op2  <= rs2_rdata_i;
          r_func <= func_t'(r_instr[FUNC_LSB +: 2]);
          if (w_rsvd_nz) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
            r_state      <= ISSUE_IDLE;
          end else begin
            r_state <= ISSUE_EXEC;
          end
        end
        ISSUE_EXEC: begin
          r_result <= alu_rd_i;
          r_rd     <= r_instr[RD_LSB +: REG_ADDR_WIDTH];
          r_state  <= ISSUE_WB;
        end
        ISSUE_WB: begin
          r_retire_cnt <= r_retire_cnt + 32'd1;
          r_state      <= ISSUE_IDLE;
        end
        default: r_state <= ISSUE_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_issue_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_gate_issue_unit                                           |
// | Description : Bench for gate_issue_unit with alu_gate and a register file. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_gate_issue_unit;

  import simple_processor_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [31:0] rs1_rdata_i, rs2_rdata_i;
  logic [31:0] alu_rs1_o, alu_rs2_o, alu_rd;
  func_t       alu_func_o;
  logic        rd_we_o, done_o, illegal_o;
  logic [31:0] rd_wdata_o, retire_cnt_o;

  always #5 clk_i = ~clk_i;

  gate_issue_unit u_dut (
    .clk_i         (clk_i),
    .arst_i        (arst_i),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .rs1_addr_o    (rs1_addr_o),
    .rs2_addr_o    (rs2_addr_o),
    .rs1_rdata_i   (rs1_rdata_i),
    .rs2_rdata_i   (rs2_rdata_i),
    .alu_rs1_o     (alu_rs1_o),
    .alu_rs2_o     (alu_rs2_o),
    .alu_func_o    (alu_func_o),
    .alu_rd_i      (alu_rd),
    .rd_we_o       (rd_we_o),
    .rd_addr_o     (rd_addr_o),
    .rd_wdata_o    (rd_wdata_o),
    .done_o        (done_o),
    .illegal_o     (illegal_o),
    .retire_cnt_o  (retire_cnt_o)
  );

  alu_gate u_alu (
    .rs1_i  (alu_rs1_o),
    .rs2_i  (alu_rs2_o),
    .func_i (alu_func_o),
    .rd_o   (alu_rd)
  );

  // Behavioural register file with a side port for preloading
  logic [31:0] rf [32];
  logic        pl_we;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk_i) begin
    if (pl_we) rf[pl_addr] <= pl_data;
    else if (rd_we_o) rf[rd_addr_o] <= rd_wdata_o;
  end

  assign rs1_rdata_i = rf[rs1_addr_o];
  assign rs2_rdata_i = rf[rs2_addr_o];

  // Reference model state
  logic [31:0] m_rf [32];
  logic [31:0] m_cnt;
  int          n_pass  = 0;
  int          n_total = 0;

  function automatic logic [31:0] mk(input int f, input int rd, input int rs1, input int rs2);
    logic [31:0] w;
    w = 32'd0;
    w[1:0]   = f[1:0];
    w[6:2]   = rd[4:0];
    w[11:7]  = rs1[4:0];
    w[16:12] = rs2[4:0];
    return w;
  endfunction

  function automatic logic [31:0] ref_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic poke(input int addr, input logic [31:0] data);
    pl_we   = 1'b1;
    pl_addr = addr[4:0];
    pl_data = data;
    m_rf[addr[4:0]] = data;
    @(negedge clk_i);
    pl_we = 1'b0;
  endtask

  // Issues one instruction and checks every cycle of it; optionally presents the next one while busy
  task automatic run(input logic [31:0] instr, input logic [31:0] next_instr, input bit hold);
    int          waited;
    logic [1:0]  f;
    logic [4:0]  rd, rs1, rs2;
    logic        ill;
    logic [31:0] exp;
    waited = 0;
    instr_i       = instr;
    instr_valid_i = 1'b1;
    while (!instr_ready_o && waited < 8) begin
      @(negedge clk_i);
      waited++;
    end
    check("ready_before_handshake", {31'd0, instr_ready_o}, 32'd1);
    if (!instr_ready_o) begin
      instr_valid_i = 1'b0;
      return;
    end
    f   = instr[1:0];
    rd  = instr[6:2];
    rs1 = instr[11:7];
    rs2 = instr[16:12];
    ill = |instr[31:17];
    exp = ref_op(f, m_rf[rs1], m_rf[rs2]);

    @(negedge clk_i);  // DECODE
    if (hold) instr_i = next_instr;
    else instr_valid_i = 1'b0;
    check("decode_ready", {31'd0, instr_ready_o}, 32'd0);
    check("decode_rs1_addr", {27'd0, rs1_addr_o}, {27'd0, rs1});
    check("decode_rs2_addr", {27'd0, rs2_addr_o}, {27'd0, rs2});
    check("decode_illegal", {31'd0, illegal_o}, {31'd0, ill});
    check("decode_done", {31'd0, done_o}, {31'd0, ill});
    check("decode_we", {31'd0, rd_we_o}, 32'd0);
    if (ill) begin
      m_cnt++;
      @(negedge clk_i);
      check("illegal_cnt", retire_cnt_o, m_cnt);
      check("illegal_after_done", {31'd0, done_o}, 32'd0);
      check("illegal_after_ready", {31'd0, instr_ready_o}, 32'd1);
      return;
    end

    @(negedge clk_i);  // EXEC
    check("exec_alu_rs1", alu_rs1_o, m_rf[rs1]);
    check("exec_alu_rs2", alu_rs2_o, m_rf[rs2]);
    check("exec_alu_func", {30'd0, alu_func_o}, {30'd0, f});
    check("exec_done", {31'd0, done_o}, 32'd0);
    check("exec_ready", {31'd0, instr_ready_o}, 32'd0);

    @(negedge clk_i);  // WB
    check("wb_done", {31'd0, done_o}, 32'd1);
    check("wb_we", {31'd0, rd_we_o}, {31'd0, rd != 5'd0});
    check("wb_rd_addr", {27'd0, rd_addr_o}, {27'd0, rd});
    check("wb_rd_wdata", rd_wdata_o, exp);
    check("wb_ready", {31'd0, instr_ready_o}, 32'd0);
    if (rd != 5'd0) m_rf[rd] = exp;
    m_cnt++;

    @(negedge clk_i);  // back in IDLE
    check("idle_cnt", retire_cnt_o, m_cnt);
    check("idle_done", {31'd0, done_o}, 32'd0);
    check("idle_ready", {31'd0, instr_ready_o}, 32'd1);
  endtask

  logic [31:0] cur, nxt;
  bit          hold_nxt;

  initial begin
    arst_i        = 1'b1;
    instr_i       = 32'd0;
    instr_valid_i = 1'b0;
    pl_we         = 1'b0;
    pl_addr       = 5'd0;
    pl_data       = 32'd0;
    m_cnt         = 32'd0;
    @(negedge clk_i);
    for (int i = 0; i < 32; i++) poke(i, (i == 0) ? 32'd0 : $urandom);

    check("rst_ready", {31'd0, instr_ready_o}, 32'd0);
    check("rst_cnt", retire_cnt_o, 32'd0);
    check("rst_wdata", rd_wdata_o, 32'd0);
    check("rst_alu_func", {30'd0, alu_func_o}, 32'd0);
    arst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_ready", {31'd0, instr_ready_o}, 32'd1);
    check("post_rst_done", {31'd0, done_o}, 32'd0);

    // Basic XOR
    poke(1, 32'hF0F0_F0F0);
    poke(2, 32'hFF00_FF00);
    run(mk(2, 3, 1, 2), 32'd0, 1'b0);
    check("xor_reg3", rf[3], 32'h0FF0_0FF0);
    check("xor_cnt", retire_cnt_o, 32'd1);

    // NOT ignores rs2
    poke(1, 32'h1234_5678);
    run(mk(3, 4, 1, 9), 32'd0, 1'b0);
    check("not_reg4", rf[4], 32'hEDCB_A987);

    // Dependent pair presented back-to-back
    poke(1, 32'hF0F0_F0F0);
    run(mk(0, 5, 1, 2), mk(1, 6, 5, 2), 1'b1);
    run(mk(1, 6, 5, 2), 32'd0, 1'b0);
    check("dep_reg5", rf[5], 32'hF000_F000);
    check("dep_reg6", rf[6], 32'hFF00_FF00);

    // Illegal reserved bit, then a write to register 0
    run(mk(1, 7, 1, 2) | 32'h0010_0000, 32'd0, 1'b0);
    check("illegal_no_write", rf[7], m_rf[7]);
    run(mk(1, 0, 1, 2), 32'd0, 1'b0);
    check("rd0_unwritten", rf[0], 32'd0);

    // Reset while in EXEC
    instr_i       = mk(2, 8, 1, 2);
    instr_valid_i = 1'b1;
    @(negedge clk_i);  // DECODE
    instr_valid_i = 1'b0;
    @(negedge clk_i);  // EXEC
    arst_i = 1'b1;
    #1;
    check("abort_we", {31'd0, rd_we_o}, 32'd0);
    check("abort_done", {31'd0, done_o}, 32'd0);
    check("abort_cnt", retire_cnt_o, 32'd0);
    check("abort_alu_rs1", alu_rs1_o, 32'd0);
    check("abort_rs1_addr", {27'd0, rs1_addr_o}, 32'd0);
    check("abort_wdata", rd_wdata_o, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    arst_i = 1'b0;
    m_cnt  = 32'd0;
    @(negedge clk_i);
    check("abort_no_write", rf[8], m_rf[8]);
    check("abort_ready", {31'd0, instr_ready_o}, 32'd1);
    run(mk(2, 9, 1, 2), 32'd0, 1'b0);
    check("after_abort_reg9", rf[9], 32'h0FF0_0FF0);

    // Random legal instructions, sometimes back-to-back
    cur = mk($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
    for (int k = 0; k < 5000; k++) begin
      nxt      = mk($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      hold_nxt = ($urandom_range(0, 1) == 1);
      run(cur, nxt, hold_nxt);
      cur = nxt;
    end
    instr_valid_i = 1'b0;
    for (int i = 0; i < 32; i++) check("final_rf", rf[i], m_rf[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_issue_unit.md
# gate_issue_unit

Sequential issue controller that drives the logic-gate ALU (`alu_gate`) from the initiator side. It accepts one 32-bit logic instruction per valid/ready handshake and decodes it. It reads both source operands from an external register file, presents them with the function code to the ALU, captures the result, and writes it back. It sits between the instruction source and the register file / `alu_gate` pair in the simple processor datapath.

## Interface
- `DATA_WIDTH`, default 32 (from `simple_processor_pkg`): operand and result width.
- `REG_ADDR_WIDTH`, default 5: register address width (32 registers).

Ports:
- `clk_i` input 1: clock; all state updates on the rising edge.
- `arst_i` input 1: reset, asynchronous, active-high.
- `instr_i` input 32: instruction word.
- `instr_valid_i` input 1: `instr_i` is valid.
- `instr_ready_o` output 1: unit can accept an instruction.
- `rs1_addr_o`, `rs2_addr_o` output `REG_ADDR_WIDTH`: register file read addresses.
- `rs1_rdata_i`, `rs2_rdata_i` input `DATA_WIDTH`: register file read data, combinational from the addresses.
- `alu_rs1_o`, `alu_rs2_o` output `DATA_WIDTH`: ALU operands.
- `alu_func_o` output `func_t`: ALU function.
- `alu_rd_i` input `DATA_WIDTH`: ALU result, combinational.
- `rd_we_o` output 1: register file write enable.
- `rd_addr_o` output `REG_ADDR_WIDTH`: write address.
- `rd_wdata_o` output `DATA_WIDTH`: write data.
- `done_o` output 1: one-cycle pulse when an instruction retires.
- `illegal_o` output 1: one-cycle pulse when an instruction is rejected.
- `retire_cnt_o` output 32: count of retired instructions, including illegal ones.

## Operation
Instruction fields:
- `[1:0]` func: AND=0, OR=1, XOR=2, NOT=3.
- `[6:2]` rd.
- `[11:7]` rs1.
- `[16:12]` rs2.
- `[31:17]` reserved; must be 0.

States: IDLE, DECODE, EXEC, WB.
- **IDLE:** `instr_ready_o`=1. If `instr_valid_i`, latch `instr_i` into the instruction register and go to DECODE.
- **DECODE:** drive `rs1_addr_o` and `rs2_addr_o` from the latched fields. Latch `rs1_rdata_i` and `rs2_rdata_i` into the operand registers. If the reserved bits are nonzero, pulse `illegal_o` and `done_o`, increment `retire_cnt_o`, and go to IDLE (no ALU issue, no write). Otherwise go to EXEC.
- **EXEC:** drive `alu_rs1_o`, `alu_rs2_o` and `alu_func_o` from the registers. Latch `alu_rd_i` into the result register. Go to WB.
- **WB:**
  - Assert `done_o`, drive `rd_addr_o` and `rd_wdata_o`, and increment `retire_cnt_o`.
  - `rd_we_o`=1 unless rd==0; writes to register 0 are suppressed, but the instruction still retires.
  - Go to IDLE.
- For NOT, rs2 is read and ignored; the result is `~rs1`.
- Outside their active states, `alu_*`, `rd_*`, `rs*_addr_o` hold their last registered values. `rd_we_o`, `done_o` and `illegal_o` are 0 there.
- `retire_cnt_o` wraps from 0xFFFF_FFFF to 0.
- `instr_valid_i` arriving while not in IDLE is ignored (`instr_ready_o`=0). The source must hold the instruction until the handshake.

## Timing
- Handshake at edge E0 (IDLE, valid && ready).
- DECODE is the cycle after E0; operands latch at E1.
- EXEC is the cycle after E1; result latches at E2.
- WB is the cycle after E2; the write occurs at E3, and `instr_ready_o` is high again after E3.
- Throughput: 1 instruction per 4 cycles. Illegal instructions take 2 cycles (`illegal_o` and `done_o` during DECODE).
- No read-after-write hazard: WB completes before the next DECODE, so back-to-back dependent instructions see the updated value.
- Reset values:
  - Outputs: all 0 (`alu_func_o`=AND), except `instr_ready_o`=1 once out of reset.
  - State and registers: state=IDLE; instruction, operand and result registers=0; `retire_cnt_o`=0.
- `arst_i` asserted mid-instruction aborts it immediately. No write occurs if it is asserted before E3. No `done_o`, and the counter is cleared.

## Structure
- `simple_processor_pkg` gains:
  - `issue_state_t` enum.
  - Field offset constants `FUNC_LSB`, `RD_LSB`, `RS1_LSB`, `RS2_LSB`, `RSVD_LSB`.
  - `REG_ADDR_WIDTH`.
- Reuses the existing `func_t` and `DATA_WIDTH`.
- Single flat module; no sub-module needed. The bench instantiates `gate_issue_unit` with `alu_gate` and a behavioural 32-entry register file.

## Test plan
- **Basic XOR:** reg1=0xF0F0_F0F0, reg2=0xFF00_FF00; instruction XOR rd=3 rs1=1 rs2=2 → in WB, `rd_we_o`=1, `rd_addr_o`=3, `rd_wdata_o`=0x0FF0_0FF0. `done_o` pulses 3 cycles after the handshake; `retire_cnt_o`=1.
- **NOT:** reg1=0x1234_5678; NOT rd=4 rs1=1 rs2=9 → write 0xEDCB_A987 to reg4.
- **Dependency:** AND rd=5 (reg1 & reg2 = 0xF000_F000), then OR rd=6 rs1=5 rs2=2 presented back-to-back → reg6=0xFF00_FF00. Handshakes are 4 cycles apart; `instr_ready_o`=0 in between.
- **Illegal and rd=0:**
  - Instruction with bit 20 set → `illegal_o` and `done_o` pulse one cycle after the handshake, no `rd_we_o`, counter increments.
  - OR with rd=0 → `done_o` pulses, `rd_we_o` stays 0.
- **Reset during EXEC:** assert `arst_i` → no write occurs, all outputs 0, state IDLE, `retire_cnt_o`=0. The next instruction executes normally.
- **Random:** 5000 random legal instructions checked against a reference model of the register file → zero mismatches.
